// File: rtl/alarm_ringer.sv
// alarm_ringer: consumer end of the alarm handshake.
// Watches the comparator's alarm_active level, drives the buzzer with a tone
// gated by a 1 s on/off cadence, handles stop/snooze/auto-timeout and holds
// alarm_clear long enough that the comparator cannot re-trigger in the same
// matching second.
//
// Input handshake: tick_1hz, btn_stop and btn_snooze are one-clk pulses.
// Each pulse is consumed on the posedge clk where it is high; there is no
// ready/acknowledge path. alarm_active is a level and is only examined in IDLE.
// alarm_clear is the level returned to the comparator; it is high for the
// whole of SNOOZE and CLEAR.
module alarm_ringer #(
    parameter int TONE_DIV       = 25000,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       alarm_active,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    output logic       alarm_clear,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_count
);

    // Counter widths; a limit of 1 still gets a 1-bit register.
    localparam int TONE_W = (TONE_DIV > 1)       ? $clog2(TONE_DIV)       : 1;
    localparam int RING_W = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
    localparam int SNZ_W  = (SNOOZE_S > 1)       ? $clog2(SNOOZE_S)       : 1;

    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_S - 1);
    localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [RING_W-1:0]   ring_sec_q, ring_sec_d;
    logic [SNZ_W-1:0]    snz_sec_q, snz_sec_d;
    logic [1:0]          snooze_cnt_q, snooze_cnt_d;
    logic                cadence_q, cadence_d;
    logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic                tone_q, tone_d;
    // Set by the first tick seen in CLEAR; the second tick returns to IDLE.
    logic                clr_seen_q, clr_seen_d;

    // Next-state and counter update for all four states.
    always_comb begin
        state_d      = state_q;
        ring_sec_d   = ring_sec_q;
        snz_sec_d    = snz_sec_q;
        snooze_cnt_d = snooze_cnt_q;
        cadence_d    = cadence_q;
        tone_cnt_d   = tone_cnt_q;
        tone_d       = tone_q;
        clr_seen_d   = clr_seen_q;

        case (state_q)
            ST_IDLE: begin
                snooze_cnt_d = '0;
                if (alarm_active) begin
                    state_d    = ST_RING;
                    ring_sec_d = '0;
                    cadence_d  = 1'b1;
                    tone_cnt_d = '0;
                    tone_d     = 1'b1;
                end
            end

            ST_RING: begin
                // Tone half-period counter runs every clk while ringing.
                if (tone_cnt_q == TONE_LAST) begin
                    tone_cnt_d = '0;
                    tone_d     = ~tone_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + TONE_W'(1);
                end

                // Stop beats snooze beats the tick (timeout or counting).
                if (btn_stop) begin
                    state_d    = ST_CLEAR;
                    clr_seen_d = 1'b0;
                end else if (btn_snooze && (snooze_cnt_q < SNZ_MAX)) begin
                    state_d      = ST_SNOOZE;
                    snooze_cnt_d = snooze_cnt_q + 2'd1;
                    snz_sec_d    = '0;
                end else if (tick_1hz) begin
                    if (ring_sec_q == RING_LAST) begin
                        state_d    = ST_CLEAR;
                        clr_seen_d = 1'b0;
                    end else begin
                        ring_sec_d = ring_sec_q + RING_W'(1);
                        cadence_d  = ~cadence_q;
                    end
                end
            end

            ST_SNOOZE: begin
                if (btn_stop) begin
                    state_d    = ST_CLEAR;
                    clr_seen_d = 1'b0;
                end else if (tick_1hz) begin
                    if (snz_sec_q == SNZ_LAST) begin
                        // Re-ring exactly as from IDLE, keeping the snooze count.
                        state_d    = ST_RING;
                        ring_sec_d = '0;
                        cadence_d  = 1'b1;
                        tone_cnt_d = '0;
                        tone_d     = 1'b1;
                    end else begin
                        snz_sec_d = snz_sec_q + SNZ_W'(1);
                    end
                end
            end

            ST_CLEAR: begin
                // Second tick after entry guarantees the comparator's matching
                // second has passed before alarm_clear drops.
                if (tick_1hz) begin
                    if (clr_seen_q) begin
                        state_d      = ST_IDLE;
                        snooze_cnt_d = '0;
                    end else begin
                        clr_seen_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ring_sec_q   <= '0;
            snz_sec_q    <= '0;
            snooze_cnt_q <= '0;
            cadence_q    <= 1'b0;
            tone_cnt_q   <= '0;
            tone_q       <= 1'b0;
            clr_seen_q   <= 1'b0;
            alarm_clear  <= 1'b0;
            buzzer       <= 1'b0;
            ringing      <= 1'b0;
            snoozing     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_sec_q   <= ring_sec_d;
            snz_sec_q    <= snz_sec_d;
            snooze_cnt_q <= snooze_cnt_d;
            cadence_q    <= cadence_d;
            tone_cnt_q   <= tone_cnt_d;
            tone_q       <= tone_d;
            clr_seen_q   <= clr_seen_d;
            alarm_clear  <= (state_d == ST_SNOOZE) || (state_d == ST_CLEAR);
            buzzer       <= (state_d == ST_RING) && tone_d && cadence_d;
            ringing      <= (state_d == ST_RING);
            snoozing     <= (state_d == ST_SNOOZE);
        end
    end

    assign snooze_count = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with TONE_DIV=4, RING_TIMEOUT_S=5,
// SNOOZE_S=3, MAX_SNOOZE=2 and a tick_1hz pulse every 100 clks.
// Inputs change 1 time unit after posedge; outputs are checked at that same
// point, i.e. after the edge that consumed the previous inputs has settled.
module tb_alarm_ringer;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       alarm_active;
    logic       btn_stop;
    logic       btn_snooze;
    logic       alarm_clear;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_count;

    int n_checks = 0;
    int n_fail   = 0;
    int phase    = 0;   // tick_1hz is applied on the cycle where phase == 99

    alarm_ringer #(
        .TONE_DIV      (4),
        .RING_TIMEOUT_S(5),
        .SNOOZE_S      (3),
        .MAX_SNOOZE    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .alarm_active(alarm_active),
        .btn_stop    (btn_stop),
        .btn_snooze  (btn_snooze),
        .alarm_clear (alarm_clear),
        .buzzer      (buzzer),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .snooze_count(snooze_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: apply tick (from phase) and button pulses, let one edge pass.
    task automatic cycle(input logic stop, input logic snz);
        tick_1hz   = (phase == 99);
        btn_stop   = stop;
        btn_snooze = snz;
        @(posedge clk);
        #1;
        phase      = (phase == 99) ? 0 : phase + 1;
        tick_1hz   = 1'b0;
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;
    endtask

    // Run idle cycles until the next cycle would carry the tick.
    task automatic run_to_pre_tick();
        for (int i = 0; i < 200 && phase != 99; i++) cycle(1'b0, 1'b0);
    endtask

    // Run idle cycles up to and including the next tick cycle.
    task automatic run_until_tick();
        run_to_pre_tick();
        cycle(1'b0, 1'b0);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare {ringing, snoozing, alarm_clear, buzzer, snooze_count}.
    task automatic check_out(input string tag, input logic r, input logic s,
                             input logic c, input logic b, input logic [1:0] cnt);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {ringing, snoozing, alarm_clear, buzzer, snooze_count};
        exp = {r, s, c, b, cnt};
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed {ring,snz,clr,buz,cnt}=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        tick_1hz     = 1'b0;
        alarm_active = 1'b0;
        btn_stop     = 1'b0;
        btn_snooze   = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle(1'b0, 1'b0);
        check_out("reset", 0, 0, 0, 0, 2'd0);

        // 1: alarm rings on the next edge; tone 4 clks high / 4 low, then silent second
        rst          = 1'b0;
        alarm_active = 1'b1;
        phase        = 0;
        cycle(1'b0, 1'b0);
        alarm_active = 1'b0;
        check_out("t1_enter", 1, 0, 0, 1, 2'd0);
        for (int k = 1; k <= 98; k++) begin
            cycle(1'b0, 1'b0);
            check("t1_tone", {7'd0, buzzer}, {7'd0, ((k / 4) % 2) == 0});
        end
        cycle(1'b0, 1'b0);  // first tick: cadence goes off
        check_out("t1_cadence_off", 1, 0, 0, 0, 2'd0);
        for (int k = 100; k <= 140; k++) begin
            cycle(1'b0, 1'b0);
            check("t1_silent", {7'd0, buzzer}, 8'd0);
        end

        // 2: stop -> CLEAR, held until the second tick after entry
        cycle(1'b1, 1'b0);
        check_out("t2_stop", 0, 0, 1, 0, 2'd0);
        run_until_tick();
        check_out("t2_guard_tick1", 0, 0, 1, 0, 2'd0);
        run_to_pre_tick();
        check_out("t2_guard_pre2", 0, 0, 1, 0, 2'd0);
        cycle(1'b0, 1'b0);
        check_out("t2_idle", 0, 0, 0, 0, 2'd0);

        // 3: snooze, re-ring after 3 ticks, second snooze, third ignored
        alarm_active = 1'b1;
        cycle(1'b0, 1'b0);
        alarm_active = 1'b0;
        check_out("t3_ring", 1, 0, 0, 1, 2'd0);
        cycle(1'b0, 1'b1);
        check_out("t3_snooze1", 0, 1, 1, 0, 2'd1);
        run_until_tick();
        run_until_tick();
        check_out("t3_snooze_hold", 0, 1, 1, 0, 2'd1);
        run_until_tick();
        check_out("t3_rering1", 1, 0, 0, 1, 2'd1);
        cycle(1'b0, 1'b1);
        check_out("t3_snooze2", 0, 1, 1, 0, 2'd2);
        run_until_tick();
        run_until_tick();
        run_until_tick();
        check_out("t3_rering2", 1, 0, 0, 1, 2'd2);
        cycle(1'b0, 1'b1);
        check_out("t3_snooze_ignored", 1, 0, 0, 1, 2'd2);

        // 4: no buttons -> timeout on the 5th tick after entry
        for (int t = 1; t <= 4; t++) begin
            run_until_tick();
            check("t4_still_ringing", {7'd0, ringing}, 8'd1);
        end
        run_to_pre_tick();
        check("t4_pre_timeout", {7'd0, ringing}, 8'd1);
        cycle(1'b0, 1'b0);
        check_out("t4_timeout", 0, 0, 1, 0, 2'd2);
        run_until_tick();
        run_until_tick();
        check_out("t4_idle", 0, 0, 0, 0, 2'd0);

        // 5a: stop and snooze together -> CLEAR, count unchanged
        alarm_active = 1'b1;
        cycle(1'b0, 1'b0);
        alarm_active = 1'b0;
        cycle(1'b0, 1'b1);
        check_out("t5_snooze1", 0, 1, 1, 0, 2'd1);
        run_until_tick();
        run_until_tick();
        run_until_tick();
        check_out("t5_rering", 1, 0, 0, 1, 2'd1);
        cycle(1'b1, 1'b1);
        check_out("t5_stop_and_snooze", 0, 0, 1, 0, 2'd1);
        run_until_tick();
        run_until_tick();
        check_out("t5_idle", 0, 0, 0, 0, 2'd0);

        // 5b: snooze coincident with the timeout tick -> SNOOZE
        alarm_active = 1'b1;
        cycle(1'b0, 1'b0);
        alarm_active = 1'b0;
        for (int t = 1; t <= 4; t++) run_until_tick();
        run_to_pre_tick();
        cycle(1'b0, 1'b1);
        check_out("t5_snooze_at_timeout", 0, 1, 1, 0, 2'd1);

        // 6: reset during SNOOZE and during RING, re-arm one cycle after rst falls
        rst = 1'b1;
        cycle(1'b0, 1'b0);
        check_out("t6_rst_in_snooze", 0, 0, 0, 0, 2'd0);
        rst          = 1'b0;
        alarm_active = 1'b1;
        cycle(1'b0, 1'b0);
        check_out("t6_rearm1", 1, 0, 0, 1, 2'd0);
        rst = 1'b1;
        cycle(1'b0, 1'b0);
        check_out("t6_rst_in_ring", 0, 0, 0, 0, 2'd0);
        rst = 1'b0;
        cycle(1'b0, 1'b0);
        check_out("t6_rearm2", 1, 0, 0, 1, 2'd0);
        alarm_active = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
Consumer end of the alarm handshake. It watches the comparator's alarm_active level and drives the buzzer with a tone gated by a 1 s on/off cadence. It handles user stop/snooze and auto-timeout, and returns alarm_clear to the comparator. alarm_clear is held long enough that the comparator cannot re-trigger within the same matching second. The block sits between the alarm comparator, the debounced button logic and the buzzer pin.

Parameters:
TONE_DIV, 25000, clk cycles per buzzer tone half-period (tone frequency = f_clk / (2*TONE_DIV)).
RING_TIMEOUT_S, 60, seconds of ringing before automatic stop.
SNOOZE_S, 300, seconds spent in snooze before re-ringing.
MAX_SNOOZE, 3, snoozes allowed per alarm event; legal range 1..3.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tick_1hz  input  1  one-clk pulse per second, same tick that advances the time counters
alarm_active  input  1  level from the alarm comparator
btn_stop  input  1  debounced one-clk pulse
btn_snooze  input  1  debounced one-clk pulse
alarm_clear  output  1  level to the comparator; high while in SNOOZE or CLEAR
buzzer  output  1  gated square-wave tone
ringing  output  1  high in RING
snoozing  output  1  high in SNOOZE
snooze_count  output  2  snoozes used in the current alarm event

Behaviour:
- Sampling and reset:
  - All inputs are sampled on posedge clk.
  - rst has priority over everything: state=IDLE; all counters=0; all outputs=0. rst mid-ring silences the buzzer on the next edge.
- Outputs: all registered and decoded from the next state, so they change on the same edge as the state.
- IDLE:
  - outputs 0, snooze_count=0.
  - alarm_active=1 -> RING next edge. On entry: ring_sec=0, cadence=1, tone counter=0, tone=1.
- RING:
  - ringing=1.
  - Tone: counter increments every clk and wraps at TONE_DIV-1; tone toggles on wrap.
  - Cadence: toggles on each tick_1hz.
  - buzzer = tone AND cadence.
  - ring_sec increments on tick_1hz.
  - Priority when several events share a cycle: btn_stop > btn_snooze > timeout. A tick in that same cycle is ignored for counting.
  - btn_stop -> CLEAR.
  - btn_snooze with snooze_count < MAX_SNOOZE -> SNOOZE; snooze_count++, snz_sec=0.
  - btn_snooze with snooze_count == MAX_SNOOZE is ignored (stays in RING).
  - Timeout: tick_1hz with ring_sec == RING_TIMEOUT_S-1 -> CLEAR.
  - alarm_active is not examined in RING.
- SNOOZE:
  - snoozing=1, alarm_clear=1, buzzer=0.
  - snz_sec increments on tick_1hz.
  - tick_1hz with snz_sec == SNOOZE_S-1 -> RING, re-initialised as on entry from IDLE; snooze_count is kept.
  - btn_stop -> CLEAR. btn_snooze is ignored.
- CLEAR:
  - alarm_clear=1, buzzer=0.
  - Stays until the second tick_1hz after entry (guard of at least 1 s, past the comparator's sec==0 window), then -> IDLE with snooze_count=0.
  - Buttons are ignored in CLEAR.
- After returning to IDLE, a new alarm_active re-arms normally.
- Counter widths: ring_sec and snz_sec are sized by $clog2 of their limit. Counters never wrap past their limit because the state exits at limit-1.

Test Plan:
Parameters for all scenarios: TONE_DIV=4, RING_TIMEOUT_S=5, SNOOZE_S=3, MAX_SNOOZE=2; tick_1hz every 100 clks.
1. Reset, then alarm_active=1 -> ringing=1 on the next edge. buzzer toggles every 4 clks during the first second and is 0 during the second; alarm_clear=0.
2. RING, then btn_stop -> alarm_clear=1 and buzzer=0 on the next edge. alarm_clear stays 1 until the 2nd tick after entry, then returns to 0 with ringing=0 and snooze_count=0.
3. RING, then btn_snooze -> snoozing=1, alarm_clear=1, snooze_count=1. On the 3rd tick, ringing=1 again.
   Second snooze -> snooze_count=2. A third btn_snooze is ignored: ringing stays 1.
4. RING with no buttons -> CLEAR on the 5th tick after entry; ringing falls in the same cycle.
5. btn_stop and btn_snooze in the same cycle during RING -> CLEAR; snooze_count unchanged.
   btn_snooze coincident with the timeout tick -> SNOOZE.
6. Assert rst during SNOOZE and during RING -> all outputs 0 on the next edge.
   alarm_active held 1 afterwards -> RING re-entered one cycle after rst falls.
